// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage: div/divu in 32 steps,
// presenting {remainder, quotient} with a ready handshake and a stall request.
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_q, rem_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [33:0] rem_shift;
  logic [32:0] diff;
  logic        q_bit;
  logic [32:0] rem_step;
  logic [31:0] dvd_step;
  logic [31:0] rem_fin;
  logic [31:0] abs_dvd;
  logic [31:0] abs_dvs;

  // One restoring step: the quotient bits shift into the low end of the dividend register.
  always_comb begin
    rem_shift = {rem_q, dvd_q[31]};
    q_bit     = (rem_shift >= {2'b00, dvs_q});
    diff      = rem_shift[32:0] - {1'b0, dvs_q};
    rem_step  = q_bit ? diff : rem_shift[32:0];
    dvd_step  = {dvd_q[30:0], q_bit};
    rem_fin   = rem_step[31:0];
    abs_dvd   = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    abs_dvs   = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = '0;
    ready_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            state_d = DIVZERO;
            dvd_d   = dividend_i;
          end else begin
            state_d    = BUSY;
            cnt_d      = '0;
            dvd_d      = abs_dvd;
            dvs_d      = abs_dvs;
            rem_d      = '0;
            neg_quot_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
            neg_rem_d  = signed_i & dividend_i[31];
          end
        end
      end
      DIVZERO: begin
        state_d  = DONE;
        ready_d  = 1'b1;
        result_d = {dvd_q, 32'hFFFF_FFFF};
      end
      BUSY: begin
        dvd_d = dvd_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = {neg_rem_q ? -rem_fin : rem_fin,
                      neg_quot_q ? -dvd_step : dvd_step};
        end
      end
      DONE: begin
        if (start_i) begin
          ready_d  = 1'b1;
          result_d = result_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Annul wins over everything except reset and drops any pending result.
    if (annul_i) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_o    = ready_q & ~annul_i;
  assign result_o   = result_q;
  assign stallreq_o = start_i & ~annul_i & (state_q != DONE);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboarded bench for ex_div: a driver issues divides and pushes model results,
// a monitor pops and compares on every rising ready_o.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];
  logic        ready_prev = 1'b0;

  ex_div #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic (truncating division, remainder follows dividend).
  function automatic logic [63:0] refModel(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sd, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = $signed(a);
      sd = $signed(b);
    end else begin
      sa = {32'd0, a};
      sd = {32'd0, b};
    end
    q = sa / sd;
    r = sa % sd;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] expv;
    int stalls;
    bit got;
    expv = refModel(sgn, a, b);
    sb.push_back(expv);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      stalls += int'(stallreq_o);
      @(posedge clk);
      #1;
      dividend_i = $urandom;
      divisor_i  = $urandom;
      signed_i   = 1'($urandom);
    end
    checkOutput("ready_seen", 64'(got), 64'd1);
    checkOutput("stall_cycles", 64'(stalls), (b == 32'd0) ? 64'd2 : 64'd33);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("done_hold_ready", 64'(ready_o), 64'd1);
    checkOutput("done_hold_stall", 64'(stallreq_o), 64'd0);
    checkOutput("done_hold_result", result_o, expv);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_ready", 64'(ready_o), 64'd0);
  endtask

  // Monitor: one comparison per rising ready_o; no ready may appear without an expectation.
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ready", result_o, 64'hDEAD_BEEF_DEAD_BEEF);
        if (result_o == 64'hDEAD_BEEF_DEAD_BEEF) begin
          miscompares++;
          $display("[TB] FAIL unexpected_ready: got ready_o=1 expected ready_o=0");
        end
      end else begin
        checkOutput("result", result_o, sb.pop_front());
      end
    end
    ready_prev = ready_o;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    rst        = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    annul_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 64'(ready_o), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    checkOutput("reset_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    applyStimulus(1'b0, 32'd100, 32'd7);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    applyStimulus(1'b0, 32'h1234_5678, 32'h0000_0000);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    $display("[TB] annul at busy step 10");
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = $urandom;
    divisor_i  = $urandom | 32'd1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul_ready", 64'(ready_o), 64'd0);
    checkOutput("annul_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    applyStimulus(1'b0, 32'd9, 32'd3);

    $display("[TB] reset at busy step 20");
    start_i    = 1'b1;
    signed_i   = 1'b1;
    dividend_i = $urandom;
    divisor_i  = $urandom | 32'd1;
    repeat (21) @(posedge clk);
    #1;
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_ready", 64'(ready_o), 64'd0);
    checkOutput("midreset_result", result_o, 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd1, 32'd1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);

    $display("[TB] random vectors");
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 20);
        1:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      applyStimulus(1'($urandom), a, b);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
